// File: rtl/ps2_key_event_filter_pkg.sv
// Shared definitions for the PS/2 key event filter.
// Contents: protocol byte codes, the discard set, the decoder state encoding,
// the queued event payload and a discard-set membership helper.
package ps2_key_event_filter_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    // Bytes that never belong to a key event (errors, BAT, echo, ack, resend).
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_NG = 8'hFC;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int unsigned SKIP_W     = 3;
    localparam logic [SKIP_W-1:0] PAUSE_SKIP = SKIP_W'(7);
    localparam int unsigned EV_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    function automatic logic is_discard(input logic [7:0] b);
        return b inside {PS2_ERR0, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
                         PS2_BAT_NG, PS2_RESEND, PS2_ERR1};
    endfunction

endpackage

// File: rtl/ps2_key_event_filter_if.sv
// Key event handshake bus between the filter (master) and a consumer (slave).
// Signals: ev_valid/ev_code/ev_ext/ev_break from master, ev_ready from slave.
interface ps2_key_event_filter_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_break,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_break,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_event_filter_ev_fifo.sv
// Synchronous first-word fall-through FIFO of key events.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, zero when
// empty), full, empty, count (0..DEPTH).
module ps2_key_event_filter_ev_fifo
    import ps2_key_event_filter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  key_event_t        din,
    input  logic              pop,
    output key_event_t        dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    key_event_t          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_event_filter.sv
// Converts the kbd_protocol byte stream into whole key events and queues them.
// Ports: clk, reset (sync, active-high), flag (byte-ready level), scancode,
// ev (event handshake, master side), overflow (sticky event loss),
// ev_count (queued events).
module ps2_key_event_filter
    import ps2_key_event_filter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned ADDR_W          = 2,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flag,
    input  logic [7:0]              scancode,
    ps2_key_event_filter_if.master  ev,
    output logic                    overflow,
    output logic [ADDR_W:0]         ev_count
);

    logic              flag_q;
    logic              byte_stb;
    dec_state_t        state;
    dec_state_t        state_nx;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_nx;
    logic              restart;
    logic              complete;
    key_event_t        cand;
    logic              held_valid;
    logic [8:0]        held;
    logic              held_match;
    logic              drop;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    key_event_t        head;

    assign byte_stb = flag && !flag_q;

    // Byte decoder: next state, skip count and completed-event candidate.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        restart  = 1'b0;
        complete = 1'b0;
        cand     = '0;
        if (byte_stb) begin
            if (state == ST_SKIP) begin
                // Pause tail bytes are swallowed whatever their value.
                if (skip_cnt == SKIP_W'(1)) state_nx = ST_IDLE;
                else                        skip_nx  = skip_cnt - SKIP_W'(1);
            end else if (is_discard(scancode)) begin
                state_nx = ST_IDLE;
            end else begin
                unique case (state)
                    ST_EXT: begin
                        if (scancode == PS2_F0)      state_nx = ST_EXTBRK;
                        else if (scancode == PS2_E0) state_nx = ST_EXT;
                        else begin
                            complete = 1'b1;
                            cand     = '{ext: 1'b1, brk: 1'b0, code: scancode};
                            state_nx = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXTBRK: begin
                        // A fresh F0/E1 mid-break means we lost sync: start over.
                        if (scancode == PS2_F0 || scancode == PS2_E1) restart = 1'b1;
                        else begin
                            complete = 1'b1;
                            cand     = '{ext: (state == ST_EXTBRK), brk: 1'b1, code: scancode};
                            state_nx = ST_IDLE;
                        end
                    end
                    default: restart = 1'b1;
                endcase

                if (restart) begin
                    if (scancode == PS2_E0)      state_nx = ST_EXT;
                    else if (scancode == PS2_F0) state_nx = ST_BRK;
                    else if (scancode == PS2_E1) begin
                        state_nx = ST_SKIP;
                        skip_nx  = PAUSE_SKIP;
                    end else begin
                        complete = 1'b1;
                        cand     = '{ext: 1'b0, brk: 1'b0, code: scancode};
                        state_nx = ST_IDLE;
                    end
                end
            end
        end
    end

    // Typematic repeats of the held key are dropped; everything else is queued.
    assign held_match = held_valid && (held == {cand.ext, cand.code});
    assign drop       = complete && !cand.brk && held_match && SUPPRESS_REPEAT;
    assign push       = complete && !drop;
    assign pop        = ev.ev_valid && ev.ev_ready;

    // Decoder state, held key and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q     <= 1'b0;
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            held_valid <= 1'b0;
            held       <= '0;
            overflow   <= 1'b0;
        end else begin
            flag_q   <= flag;
            state    <= state_nx;
            skip_cnt <= skip_nx;
            if (complete) begin
                if (!cand.brk) begin
                    if (!held_match) begin
                        held_valid <= 1'b1;
                        held       <= {cand.ext, cand.code};
                    end
                end else if (held_match) begin
                    held_valid <= 1'b0;
                end
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    ps2_key_event_filter_ev_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ev_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (cand),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (ev_count)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_code  = head.code;
    assign ev.ev_ext   = head.ext;
    assign ev.ev_break = head.brk;

endmodule

// File: tb/tb_ps2_key_event_filter.sv
// Directed bench for ps2_key_event_filter with an expected-event scoreboard.
module tb_ps2_key_event_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset2;
    logic       flag;
    logic [7:0] scancode;
    logic       overflow;
    logic       overflow2;
    logic [2:0] ev_count;
    logic [2:0] ev_count2;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_ev2    = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_key_event_filter_if ev_if ();
    ps2_key_event_filter_if ev2_if ();

    assign ev2_if.ev_ready = 1'b1;

    ps2_key_event_filter #(
        .FIFO_DEPTH      (4),
        .ADDR_W          (2),
        .SUPPRESS_REPEAT (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flag     (flag),
        .scancode (scancode),
        .ev       (ev_if),
        .overflow (overflow),
        .ev_count (ev_count)
    );

    // Same byte stream, repeats not suppressed; only its event count is tracked.
    ps2_key_event_filter #(
        .FIFO_DEPTH      (4),
        .ADDR_W          (2),
        .SUPPRESS_REPEAT (1'b0)
    ) dut_nr (
        .clk      (clk),
        .reset    (reset2),
        .flag     (flag),
        .scancode (scancode),
        .ev       (ev2_if),
        .overflow (overflow2),
        .ev_count (ev_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at the negedge: score any event the DUT hands over at the next edge.
    task automatic mon();
        logic [9:0] obs;
        if (ev2_if.ev_valid) n_ev2++;
        if (ev_if.ev_valid && ev_if.ev_ready) begin
            obs = {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code};
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL spurious_event: observed 0x%0h expected no event", obs);
            if (exp_q.size() != 0) chk("event {ext,brk,code}", 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        flag     = 1'b1;
        scancode = b;
        tick();
        flag     = 1'b0;
        tick();
    endtask

    // Completing byte into an empty FIFO: valid must appear exactly one cycle later.
    task automatic send_timed(input logic [7:0] b);
        flag     = 1'b1;
        scancode = b;
        @(negedge clk);
        chk("latency_valid_before", 32'(ev_if.ev_valid), 32'd0);
        mon();
        @(posedge clk);
        #1;
        flag = 1'b0;
        @(negedge clk);
        chk("latency_valid_after", 32'(ev_if.ev_valid), 32'd1);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    32'(ev_if.ev_valid), 32'd0);
        chk({tag, "_code"},     32'(ev_if.ev_code),  32'd0);
        chk({tag, "_ext"},      32'(ev_if.ev_ext),   32'd0);
        chk({tag, "_break"},    32'(ev_if.ev_break), 32'd0);
        chk({tag, "_count"},    32'(ev_count),       32'd0);
        chk({tag, "_overflow"}, 32'(overflow),       32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        reset2         = 1'b1;
        flag           = 1'b0;
        scancode       = 8'h00;
        ev_if.ev_ready = 1'b0;
        idle(3);
        chk_reset_outputs("reset");
        reset          = 1'b0;
        reset2         = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick();

        // Plain make then break.
        exp_q.push_back(10'h01C);
        send_timed(8'h1C);
        send_byte(8'hF0);
        exp_q.push_back(10'h11C);
        send_timed(8'h1C);
        idle(3);
        chk("t1_all_seen", 32'(exp_q.size()), 32'd0);

        // Extended make and break; prefixes stripped.
        send_byte(8'hE0);
        exp_q.push_back(10'h275);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        exp_q.push_back(10'h375);
        send_byte(8'h75);
        idle(3);
        chk("t2_all_seen", 32'(exp_q.size()), 32'd0);

        // Typematic repeats: suppressed on dut, all kept on dut_nr.
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        n_ev2  = 0;
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        exp_q.push_back(10'h11C);
        send_byte(8'h1C);
        idle(3);
        chk("t3_all_seen", 32'(exp_q.size()), 32'd0);
        chk("t3_norepeat_events", 32'(n_ev2), 32'd4);
        chk("t3_norepeat_count", 32'(ev_count2), 32'd0);
        chk("t3_norepeat_overflow", 32'(overflow2), 32'd0);

        // Pause sequence and discard-set bytes produce nothing.
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        exp_q.push_back(10'h029);
        send_byte(8'h29);
        send_byte(8'hAA);
        send_byte(8'hFA);
        idle(3);
        chk("t4_all_seen", 32'(exp_q.size()), 32'd0);
        chk("t4_count", 32'(ev_count), 32'd0);

        // Overflow with the consumer stalled, then drain in order.
        ev_if.ev_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        chk("t5_overflow_at_full", 32'(overflow), 32'd0);
        send_byte(8'h24);
        send_byte(8'h2B);
        chk("t5_count_full", 32'(ev_count), 32'd4);
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_valid", 32'(ev_if.ev_valid), 32'd1);
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h032);
        exp_q.push_back(10'h021);
        exp_q.push_back(10'h023);
        ev_if.ev_ready = 1'b1;
        idle(6);
        chk("t5_all_seen", 32'(exp_q.size()), 32'd0);
        chk("t5_count_drained", 32'(ev_count), 32'd0);
        chk("t5_overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-sequence with a queued event, then single strobe on a held flag.
        ev_if.ev_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        chk("t6_queued_before_reset", 32'(ev_count), 32'd1);
        reset = 1'b1;
        tick();
        chk_reset_outputs("t6_in_reset");
        tick();
        chk_reset_outputs("t6_in_reset2");
        reset          = 1'b0;
        ev_if.ev_ready = 1'b1;
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        idle(2);
        send_byte(8'hF0);
        exp_q.push_back(10'h11C);
        flag     = 1'b1;
        scancode = 8'h1C;
        idle(20);
        flag = 1'b0;
        idle(4);
        chk("t6_all_seen", 32'(exp_q.size()), 32'd0);
        chk("t6_count", 32'(ev_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
